sine_analyzer: RTL and testbench



---
 rtl/sine_analyzer_pkg.sv | 15 +
 rtl/sine_xing_det.sv | 41 ++++
 rtl/sine_analyzer.sv | 142 ++++++++++++++
 tb/tb_sine_analyzer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_analyzer_pkg.sv
// Shared types and defaults for the sine analyzer.
// Contents: FSM state type, default sample MSB index and period width,
// and the averaging depth used when SINE_ANALYZER_AVG_EN is defined.
package sine_analyzer_pkg;

   localparam int unsigned DEF_N    = 15;
   localparam int unsigned DEF_PW   = 16;
   localparam int unsigned AVG_LOG2 = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/sine_xing_det.sv
// Rising zero-crossing detector with hysteresis.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   sample_in     - signed sample, N+1 bits
//   sample_valid  - sample_in accepted on this edge
//   clear         - drop the arm flag (cycle abandoned)
//   xing_c        - combinational crossing flag for the presented sample
module sine_xing_det #(
   parameter int unsigned N    = 15,
   parameter int unsigned HYST = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic signed [N:0] sample_in,
   input  logic              sample_valid,
   input  logic              clear,
   output logic              xing_c
);

   localparam logic signed [N:0] THR_HI = (N+1)'(HYST);
   localparam logic signed [N:0] THR_LO = -THR_HI;

   logic arm_q;

   // A crossing needs arm from an earlier sample, so one sample cannot arm and cross.
   assign xing_c = sample_valid && arm_q && (sample_in >= THR_HI);

   // Arm on a deep negative sample; disarm on crossing or abandon.
   always_ff @(posedge clk) begin
      if (reset) begin
         arm_q <= 1'b0;
      end else if (sample_valid) begin
         if (xing_c || clear) begin
            arm_q <= 1'b0;
         end else if (sample_in <= THR_LO) begin
            arm_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sine_analyzer.sv
// Sine stream analyzer: measures period (in samples) and half peak-to-peak
// amplitude per cycle, using rising zero crossings with hysteresis.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   sample_in     - signed sample, N+1 bits
//   sample_valid  - sample_in accepted on this edge
//   period        - samples per cycle of the last completed cycle
//   amplitude     - (max-min)>>1 of the last completed cycle, unsigned
//   result_valid  - one-cycle pulse when period/amplitude update
//   timeout       - one-cycle pulse when a cycle is abandoned
//   locked        - high while in RUN
// Optional: define SINE_ANALYZER_AVG_EN to report the mean period of four
// consecutive cycles (one result per four crossings).
module sine_analyzer
   import sine_analyzer_pkg::*;
#(
   parameter int unsigned N          = DEF_N,
   parameter int unsigned PW         = DEF_PW,
   parameter int unsigned HYST       = 64,
   parameter int unsigned MAX_PERIOD = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic signed [N:0] sample_in,
   input  logic              sample_valid,
   output logic [PW-1:0]     period,
   output logic [N:0]        amplitude,
   output logic              result_valid,
   output logic              timeout,
   output logic              locked
);

   localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PERIOD);

   state_t              state_q;
   logic [PW-1:0]       count_q;
   logic signed [N:0]   max_q;
   logic signed [N:0]   min_q;
   logic                xing_c;
   logic                timeout_c;
   logic [N+1:0]        diff_c;
   logic [N:0]          amp_c;

   // Abandon the cycle when the counter is full and no crossing arrives.
   assign timeout_c = sample_valid && (state_q == RUN) && !xing_c && (count_q == MAX_CNT);

   // max >= min always, so the N+2-bit difference is non-negative.
   assign diff_c = {max_q[N], max_q} - {min_q[N], min_q};
   assign amp_c  = (N+1)'(diff_c >> 1);

   sine_xing_det #(
      .N    (N),
      .HYST (HYST)
   ) u_xing_det (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .clear        (timeout_c),
      .xing_c       (xing_c)
   );

`ifdef SINE_ANALYZER_AVG_EN
   logic [PW+1:0]       acc_q;
   logic [AVG_LOG2-1:0] acc_cnt_q;
   logic [PW+1:0]       sum_c;

   assign sum_c = acc_q + (PW+2)'(count_q);
`endif

   // Cycle FSM, measurement registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         max_q        <= '0;
         min_q        <= '0;
         period       <= '0;
         amplitude    <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
         locked       <= 1'b0;
`ifdef SINE_ANALYZER_AVG_EN
         acc_q        <= '0;
         acc_cnt_q    <= '0;
`endif
      end else begin
         result_valid <= 1'b0;
         timeout      <= 1'b0;
         if (sample_valid) begin
            case (state_q)
               IDLE: begin
                  if (xing_c) begin
                     state_q <= RUN;
                     locked  <= 1'b1;
                     count_q <= PW'(1);
                     max_q   <= sample_in;
                     min_q   <= sample_in;
                  end
               end
               RUN: begin
                  if (xing_c) begin
`ifdef SINE_ANALYZER_AVG_EN
                     if (acc_cnt_q == {AVG_LOG2{1'b1}}) begin
                        period       <= PW'(sum_c >> AVG_LOG2);
                        amplitude    <= amp_c;
                        result_valid <= 1'b1;
                        acc_q        <= '0;
                        acc_cnt_q    <= '0;
                     end else begin
                        acc_q        <= sum_c;
                        acc_cnt_q    <= acc_cnt_q + AVG_LOG2'(1);
                     end
`else
                     period       <= count_q;
                     amplitude    <= amp_c;
                     result_valid <= 1'b1;
`endif
                     // Crossing sample opens the next cycle.
                     count_q <= PW'(1);
                     max_q   <= sample_in;
                     min_q   <= sample_in;
                  end else if (timeout_c) begin
                     state_q <= IDLE;
                     locked  <= 1'b0;
                     timeout <= 1'b1;
`ifdef SINE_ANALYZER_AVG_EN
                     acc_q     <= '0;
                     acc_cnt_q <= '0;
`endif
                  end else begin
                     count_q <= count_q + PW'(1);
                     if (sample_in > max_q) max_q <= sample_in;
                     if (sample_in < min_q) min_q <= sample_in;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sine_analyzer.sv
// Self-checking bench for sine_analyzer: directed table plus triangle-wave,
// hysteresis, timeout, mid-cycle reset and (with SINE_ANALYZER_AVG_EN)
// period-averaging sequences.
module tb_sine_analyzer;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] sample_in;
   logic               sample_valid;
   logic [15:0]        period;
   logic [15:0]        amplitude;
   logic               result_valid;
   logic               timeout;
   logic               locked;

   int total = 0;
   int bad   = 0;

   sine_analyzer dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .period       (period),
      .amplitude    (amplitude),
      .result_valid (result_valid),
      .timeout      (timeout),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      bit v;
      bit rv;
      int per;
      int amp;
      bit lck;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Present one sample, then sample outputs 1 time unit after the edge.
   task automatic drive(input int s, input bit v);
      sample_in    = 16'(s);
      sample_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Triangle +-1000, step 40, 100 samples per cycle; rising crossing at 80 (k%100==27).
   function automatic int tri_wave(input int k);
      int p;
      p = k % 100;
      if (p < 50) return -1000 + 40 * p;
      return 1000 - 40 * (p - 50);
   endfunction

   initial begin
      int   npulse;
      int   first_k;
      int   last_k;
      int   rv_bad;
      int   lck_seen;
      int   to_at;
      vec_t tbl[9];

      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_period", int'(period), 0);
      chk("reset_amplitude", int'(amplitude), 0);
      chk("reset_result_valid", int'(result_valid), 0);
      chk("reset_timeout", int'(timeout), 0);
      chk("reset_locked", int'(locked), 0);
      reset = 1'b0;

`ifndef SINE_ANALYZER_AVG_EN
      // Hysteresis boundaries and full-scale amplitude.
      tbl[0] = '{s: -64,    v: 1, rv: 0, per: 0, amp: 0,     lck: 0};
      tbl[1] = '{s: 63,     v: 1, rv: 0, per: 0, amp: 0,     lck: 0};
      tbl[2] = '{s: 64,     v: 1, rv: 0, per: 0, amp: 0,     lck: 1};
      tbl[3] = '{s: 32767,  v: 1, rv: 0, per: 0, amp: 0,     lck: 1};
      tbl[4] = '{s: -32768, v: 1, rv: 0, per: 0, amp: 0,     lck: 1};
      tbl[5] = '{s: 1000,   v: 0, rv: 0, per: 0, amp: 0,     lck: 1};
      tbl[6] = '{s: 100,    v: 1, rv: 1, per: 3, amp: 32767, lck: 1};
      tbl[7] = '{s: 100,    v: 1, rv: 0, per: 3, amp: 32767, lck: 1};
      tbl[8] = '{s: 0,      v: 0, rv: 0, per: 3, amp: 32767, lck: 1};
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].s, tbl[i].v);
         chk($sformatf("tbl%0d_rv", i), int'(result_valid), int'(tbl[i].rv));
         chk($sformatf("tbl%0d_period", i), int'(period), tbl[i].per);
         chk($sformatf("tbl%0d_amp", i), int'(amplitude), tbl[i].amp);
         chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lck));
      end

      // Triangle, valid every clock.
      do_reset();
      npulse = 0; first_k = -1; last_k = -1;
      for (int k = 0; k < 400; k++) begin
         drive(tri_wave(k), 1'b1);
         if (result_valid) begin
            npulse++;
            if (first_k < 0) first_k = k;
            last_k = k;
         end
      end
      chk("tri_pulses", npulse, 3);
      chk("tri_first_pulse", first_k, 127);
      chk("tri_pulse_span", last_k - first_k, 200);
      chk("tri_period", int'(period), 100);
      chk("tri_amplitude", int'(amplitude), 1000);
      chk("tri_locked", int'(locked), 1);

      // Triangle, valid every other clock.
      do_reset();
      npulse = 0; first_k = -1; last_k = -1; rv_bad = 0;
      for (int k = 0; k < 400; k++) begin
         drive(tri_wave(k), 1'b1);
         if (result_valid) begin
            npulse++;
            if (first_k < 0) first_k = 2 * k;
            last_k = 2 * k;
         end
         drive(tri_wave(k + 1), 1'b0);
         if (result_valid) rv_bad++;
      end
      chk("half_pulses", npulse, 3);
      chk("half_pulse_gap_clks", (last_k - first_k) / 2, 200);
      chk("half_rv_on_idle_clk", rv_bad, 0);
      chk("half_period", int'(period), 100);
`endif

      // Signal inside the hysteresis band never arms.
      do_reset();
      npulse = 0; lck_seen = 0;
      for (int k = 0; k < 200; k++) begin
         drive((k % 2 == 0) ? 50 : -50, 1'b1);
         if (result_valid) npulse++;
         if (locked) lck_seen++;
      end
      chk("small_pulses", npulse, 0);
      chk("small_locked", lck_seen, 0);

      // Lock, then hold zero until the cycle is abandoned.
      do_reset();
      for (int k = 0; k < 128; k++) drive(tri_wave(k), 1'b1);
      chk("to_locked_before", int'(locked), 1);
      to_at = -1; npulse = 0;
      for (int z = 1; z <= 70000; z++) begin
         drive(0, 1'b1);
         if (result_valid) npulse++;
         if (timeout) begin
            to_at = z;
            break;
         end
      end
      chk("to_sample_index", to_at, 65535);
      chk("to_locked_after", int'(locked), 0);
`ifndef SINE_ANALYZER_AVG_EN
      chk("to_period_held", int'(period), 100);
      chk("to_amplitude_held", int'(amplitude), 1000);
`else
      chk("to_period_held", int'(period), 0);
`endif
      chk("to_no_result", npulse, 0);
      drive(0, 1'b1);
      chk("to_pulse_one_cycle", int'(timeout), 0);

      // Reset in mid-cycle.
      do_reset();
      for (int k = 0; k < 250; k++) drive(tri_wave(k), 1'b1);
      reset = 1'b1;
      drive(tri_wave(250), 1'b1);
      reset = 1'b0;
      chk("mr_period", int'(period), 0);
      chk("mr_amplitude", int'(amplitude), 0);
      chk("mr_locked", int'(locked), 0);
      chk("mr_result_valid", int'(result_valid), 0);
      chk("mr_timeout", int'(timeout), 0);
`ifndef SINE_ANALYZER_AVG_EN
      first_k = -1;
      for (int k = 251; k < 430; k++) begin
         drive(tri_wave(k), 1'b1);
         if (result_valid && first_k < 0) first_k = k;
      end
      chk("mr_next_result_k", first_k, 427);
      chk("mr_next_period", int'(period), 100);
`endif

`ifdef SINE_ANALYZER_AVG_EN
      // Periods 98, 102, 100, 100; last cycle has min -600.
      begin
         int pers[4];
         int xk;
         pers[0] = 98; pers[1] = 102; pers[2] = 100; pers[3] = 100;
         do_reset();
         drive(-1000, 1'b1);
         drive(1000, 1'b1);
         npulse = 0; xk = -1;
         for (int c = 0; c < 4; c++) begin
            drive((c == 3) ? -600 : -1000, 1'b1);
            for (int j = 0; j < pers[c] - 2; j++) drive(0, 1'b1);
            drive(1000, 1'b1);
            if (result_valid) begin
               npulse++;
               xk = c;
            end
         end
         chk("avg_pulses", npulse, 1);
         chk("avg_pulse_crossing", xk, 3);
         chk("avg_period", int'(period), 100);
         chk("avg_amplitude", int'(amplitude), 800);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
